four_and_gate: RTL and testbench

- Registered four-input AND block built from three 2-input AND stages: e = a&b, f = c&d, g = e&f = a&b&c&d.
- Exposes both partial products (e, f) and the full product (g) so downstream logic can use pairwise or four-way coincidence.
- Bit-wise over a parameterised vector width. One clock domain, one-cycle latency, with a valid flag carried alongside the data.

---
 rtl/four_and_gate_pkg.sv | 27 ++
 rtl/four_and_gate_if.sv | 27 ++
 rtl/four_and_gate_and2_cell.sv | 10 +
 rtl/four_and_gate.sv | 67 ++++++
 tb/tb_four_and_gate.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/four_and_gate_pkg.sv
// Shared definitions for the four-input AND block: default width and a
// reference function that produces the packed {e, f, g} result.
package four_and_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] e;
        logic [MAX_WIDTH-1:0] f;
        logic [MAX_WIDTH-1:0] g;
    } and4_res_t;

    function automatic and4_res_t and4_ref(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic [MAX_WIDTH-1:0] c,
        input logic [MAX_WIDTH-1:0] d
    );
        and4_res_t r;
        r.e = a & b;
        r.f = c & d;
        r.g = r.e & r.f;
        return r;
    endfunction

endpackage

// File: rtl/four_and_gate_if.sv
// Operand/result bundle for four_and_gate; master drives operands,
// slave (the block) returns the partial and full products.
interface four_and_gate_if
    import four_and_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;

    modport master (
        output in_valid, a, b, c, d,
        input  out_valid, e, f, g
    );

    modport slave (
        input  in_valid, a, b, c, d,
        output out_valid, e, f, g
    );
endinterface

// File: rtl/four_and_gate_and2_cell.sv
// Bitwise two-input AND over WIDTH independent lanes.
module and2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

// File: rtl/four_and_gate.sv
// Four-input AND built from three and2_cell stages, exposing both pairwise
// products and the full product, optionally registered with a valid flag.
module four_and_gate
    import four_and_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    four_and_gate_if.slave  bus
);
    logic [WIDTH-1:0] e_n;
    logic [WIDTH-1:0] f_n;
    logic [WIDTH-1:0] g_n;

    and2_cell #(.WIDTH(WIDTH)) u_ab (.a_i(bus.a), .b_i(bus.b), .y_o(e_n));
    and2_cell #(.WIDTH(WIDTH)) u_cd (.a_i(bus.c), .b_i(bus.d), .y_o(f_n));
    // g is taken from e_n/f_n so the three outputs can never disagree.
    and2_cell #(.WIDTH(WIDTH)) u_ef (.a_i(e_n),   .b_i(f_n),   .y_o(g_n));

    if (REG_OUT) begin : g_reg
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] e_q, e_d;
        logic [WIDTH-1:0] f_q, f_d;
        logic [WIDTH-1:0] g_q, g_d;

        always_comb begin
            // NOTE: every always_comb target gets a default first so no latch is inferred.
            valid_d = bus.in_valid;
            e_d     = e_q;
            f_d     = f_q;
            g_d     = g_q;
            // Unqualified operands (possibly X) never reach the registers.
            if (bus.in_valid) begin
                e_d = e_n;
                f_d = f_n;
                g_d = g_n;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: state updates use <= so every register samples pre-edge values.
            if (rst) begin
                valid_q <= 1'b0;
                e_q     <= '0;
                f_q     <= '0;
                g_q     <= '0;
            end else begin
                valid_q <= valid_d;
                e_q     <= e_d;
                f_q     <= f_d;
                g_q     <= g_d;
            end
        end

        assign bus.out_valid = valid_q;
        assign bus.e         = e_q;
        assign bus.f         = f_q;
        assign bus.g         = g_q;
    end else begin : g_comb
        assign bus.out_valid = rst ? 1'b0 : bus.in_valid;
        assign bus.e         = rst ? '0   : e_n;
        assign bus.f         = rst ? '0   : f_n;
        assign bus.g         = rst ? '0   : g_n;
    end
endmodule

// File: tb/tb_four_and_gate.sv
// Directed-vector bench for four_and_gate: reset, truth table, lane
// independence, hold, mid-stream reset and the combinational variant.
module tb_four_and_gate;
    import four_and_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    four_and_gate_if #(.WIDTH(1)) bus1 ();
    four_and_gate_if #(.WIDTH(4)) bus4 ();
    four_and_gate_if #(.WIDTH(1)) bus0 ();

    four_and_gate #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    four_and_gate #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    four_and_gate #(.WIDTH(1), .REG_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c, input logic d);
        bus1.in_valid = v;
        bus1.a = a; bus1.b = b; bus1.c = c; bus1.d = d;
    endtask

    task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        bus4.in_valid = v;
        bus4.a = a; bus4.b = b; bus4.c = c; bus4.d = d;
    endtask

    initial begin
        and4_res_t        r;
        logic [3:0]       ra, rb, rc, rd;
        logic             ea, eb, ec, ed;

        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drive4(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        bus0.in_valid = 1'b1;
        bus0.a = 1'b1; bus0.b = 1'b1; bus0.c = 1'b1; bus0.d = 1'b1;
        rst = 1'b1;

        // Reset held three cycles with all-ones valid operands.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_e", 32'(bus1.e), 32'd0);
            check("rst_f", 32'(bus1.f), 32'd0);
            check("rst_g", 32'(bus1.g), 32'd0);
            check("rst_vld", 32'(bus1.out_valid), 32'd0);
        end
        check("comb_rst_g", 32'(bus0.g), 32'd0);
        check("comb_rst_vld", 32'(bus0.out_valid), 32'd0);

        rst = 1'b0;
        #1;
        check("comb_all1_g", 32'(bus0.g), 32'd1);
        check("comb_all1_e", 32'(bus0.e), 32'd1);
        check("comb_all1_vld", 32'(bus0.out_valid), 32'd1);
        bus0.c = 1'b0;
        #1;
        check("comb_1101_e", 32'(bus0.e), 32'd1);
        check("comb_1101_f", 32'(bus0.f), 32'd0);
        check("comb_1101_g", 32'(bus0.g), 32'd0);
        rst = 1'b1;
        #1;
        check("comb_rst_now_e", 32'(bus0.e), 32'd0);
        check("comb_rst_now_vld", 32'(bus0.out_valid), 32'd0);
        rst = 1'b0;

        step();
        check("post_rst_e", 32'(bus1.e), 32'd1);
        check("post_rst_f", 32'(bus1.f), 32'd1);
        check("post_rst_g", 32'(bus1.g), 32'd1);
        check("post_rst_vld", 32'(bus1.out_valid), 32'd1);

        // Exhaustive WIDTH=1 truth table; index bits are {d,c,b,a}.
        for (int i = 0; i < 16; i++) begin
            ea = i[0]; eb = i[1]; ec = i[2]; ed = i[3];
            drive1(1'b1, ea, eb, ec, ed);
            step();
            check($sformatf("tt%0d_e", i), 32'(bus1.e), 32'(ea && eb));
            check($sformatf("tt%0d_f", i), 32'(bus1.f), 32'(ec && ed));
            check($sformatf("tt%0d_g", i), 32'(bus1.g), (i == 15) ? 32'd1 : 32'd0);
            check($sformatf("tt%0d_vld", i), 32'(bus1.out_valid), 32'd1);
        end
        drive1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("tt_1101_e", 32'(bus1.e), 32'd1);
        check("tt_1101_f", 32'(bus1.f), 32'd0);
        check("tt_1101_g", 32'(bus1.g), 32'd0);

        // Lane independence at WIDTH=4.
        drive4(1'b1, 4'b1111, 4'b1010, 4'b0110, 4'b1110);
        step();
        check("lane_e", 32'(bus4.e), 32'b1010);
        check("lane_f", 32'(bus4.f), 32'b0110);
        check("lane_g", 32'(bus4.g), 32'b0010);
        check("lane_vld", 32'(bus4.out_valid), 32'd1);

        // Hold: one valid all-ones result, then five idle cycles of zeros.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("hold_load_g", 32'(bus1.g), 32'd1);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold%0d_e", i), 32'(bus1.e), 32'd1);
            check($sformatf("hold%0d_f", i), 32'(bus1.f), 32'd1);
            check($sformatf("hold%0d_g", i), 32'(bus1.g), 32'd1);
            check($sformatf("hold%0d_vld", i), 32'(bus1.out_valid), 32'd0);
        end

        // Continuous valid random stream with a one-cycle reset in the middle.
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
            drive4(1'b1, ra, rb, rc, rd);
            rst = (i == 5);
            step();
            if (i == 5) begin
                check("mid_rst_g", 32'(bus4.g), 32'd0);
                check("mid_rst_e", 32'(bus4.e), 32'd0);
                check("mid_rst_vld", 32'(bus4.out_valid), 32'd0);
            end else begin
                r = and4_ref(32'(ra), 32'(rb), 32'(rc), 32'(rd));
                check($sformatf("strm%0d_e", i), 32'(bus4.e), 32'(r.e[3:0]));
                check($sformatf("strm%0d_f", i), 32'(bus4.f), 32'(r.f[3:0]));
                check($sformatf("strm%0d_g", i), 32'(bus4.g), 32'(r.g[3:0]));
                check($sformatf("strm%0d_vld", i), 32'(bus4.out_valid), 32'd1);
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
